out_port_alloc_r24: RTL and testbench

- Generates the per-input grants g40..g44 for output port 4 of the 5-port router.
- These grants feed the port-4 one-hot crossbar selector.
- Round-robin arbitration among the five input ports; the grant is held for a whole packet, head flit to tail flit.
- Drives the valid/ready handshake between the granted input buffer and the output link, and has a watchdog that frees a stuck grant.

---
 rtl/out_port_alloc_r24_pkg.sv | 27 ++
 rtl/out_port_alloc_r24_rr_pick5.sv | 30 +++
 rtl/out_port_alloc_r24.sv | 113 +++++++++++
 tb/tb_out_port_alloc_r24.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/out_port_alloc_r24_pkg.sv
// Shared router definitions: port indices, allocator state encoding and a
// small one-hot helper used by every output allocator.
package out_port_alloc_r24_pkg;

    localparam int NPORTS = 5;

    localparam logic [2:0] P_LOCAL = 3'd0;
    localparam logic [2:0] P_1     = 3'd1;
    localparam logic [2:0] P_2     = 3'd2;
    localparam logic [2:0] P_3     = 3'd3;
    localparam logic [2:0] P_4     = 3'd4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic logic [NPORTS-1:0] onehot5(input logic [2:0] idx);
        logic [NPORTS-1:0] v;
        v = '0;
        for (int i = 0; i < NPORTS; i++) begin
            v[i] = (idx == 3'(i));
        end
        return v;
    endfunction

endpackage

// File: rtl/out_port_alloc_r24_rr_pick5.sv
// Combinational round-robin picker: first set req bit scanning upward from
// ptr, wrapping 4 -> 0. Shared by all five output allocators.
module rr_pick5
    import out_port_alloc_r24_pkg::*;
(
    input  logic [NPORTS-1:0] req,
    input  logic [2:0]        ptr,
    output logic [2:0]        winner,
    output logic              found
);

    logic [3:0] idx;

    always_comb begin
        found  = 1'b0;
        winner = P_LOCAL;
        idx    = '0;
        for (int k = 0; k < NPORTS; k++) begin
            idx = {1'b0, ptr} + 4'(k);
            if (idx >= 4'(NPORTS)) begin
                idx = idx - 4'(NPORTS);
            end
            if (!found && req[idx[2:0]]) begin
                found  = 1'b1;
                winner = idx[2:0];
            end
        end
    end

endmodule

// File: rtl/out_port_alloc_r24.sv
// Output-port-4 allocator: round-robin grant held for a whole packet, flit
// handshake between the granted input and the link, and a stall watchdog.
module out_port_alloc_r24
    import out_port_alloc_r24_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NPORTS-1:0] req,
    input  logic [NPORTS-1:0] in_valid,
    input  logic [NPORTS-1:0] in_tail,
    input  logic              out_ready,
    output logic [NPORTS-1:0] gnt,
    output logic [NPORTS-1:0] in_ready,
    output logic              out_valid,
    output logic              busy,
    output logic              err_timeout
);

    // Handshake: a flit moves when out_valid and out_ready are both high in
    // the same cycle; in_ready[i] mirrors out_ready to the granted input only,
    // independent of in_valid, so neither side waits on the other.

    state_t               state, state_nx;
    logic [NPORTS-1:0]    gnt_nx;
    logic [2:0]           ptr, ptr_nx;
    logic [CNT_W-1:0]     cnt, cnt_nx;
    logic                 err_nx;

    logic [2:0]           pick_w;
    logic                 pick_found;
    logic [2:0]           w;
    logic                 valid_w;
    logic                 tail_w;
    logic                 fire;

    rr_pick5 u_pick (
        .req    (req),
        .ptr    (ptr),
        .winner (pick_w),
        .found  (pick_found)
    );

    always_comb begin
        w = P_LOCAL;
        for (int i = 0; i < NPORTS; i++) begin
            if (gnt[i]) begin
                w = 3'(i);
            end
        end
    end

    assign busy      = (state == BUSY);
    assign valid_w   = |(in_valid & gnt);
    assign tail_w    = |(in_tail & gnt);
    assign fire      = busy & valid_w & out_ready;
    assign out_valid = busy & valid_w;
    assign in_ready  = gnt & {NPORTS{busy & out_ready}};

    always_comb begin
        state_nx = state;
        gnt_nx   = gnt;
        ptr_nx   = ptr;
        cnt_nx   = cnt;
        err_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    gnt_nx   = onehot5(pick_w);
                    cnt_nx   = '0;
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                // A tail fire wins over a coincident timeout: normal release.
                if ((fire && tail_w) || (!fire && cnt == CNT_W'(TIMEOUT - 1))) begin
                    gnt_nx   = '0;
                    cnt_nx   = '0;
                    ptr_nx   = (w == P_4) ? P_LOCAL : w + 3'd1;
                    state_nx = IDLE;
                    err_nx   = !fire;
                end else if (fire) begin
                    cnt_nx = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                gnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            gnt         <= '0;
            ptr         <= P_LOCAL;
            cnt         <= '0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_nx;
            gnt         <= gnt_nx;
            ptr         <= ptr_nx;
            cnt         <= cnt_nx;
            err_timeout <= err_nx;
        end
    end

endmodule

// File: tb/tb_out_port_alloc_r24.sv
// Bench for the port-4 allocator: directed scenarios plus random traffic
// checked against a packet-level model of ownership, priority and stalls.
module tb_out_port_alloc_r24;

    localparam int TIMEOUT = 255;

    logic       clk;
    logic       rst_n;
    logic [4:0] req, in_valid, in_tail;
    logic       out_ready;
    logic [4:0] gnt, in_ready;
    logic       out_valid, busy, err_timeout;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: which input owns the port (-1 none), who is next in line,
    // and how many consecutive cycles the owner has gone without a transfer.
    int m_owner;
    int m_ptr;
    int m_wait;
    bit m_err;

    logic [2:0] exp_q[$];

    out_port_alloc_r24 #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .in_valid    (in_valid),
        .in_tail     (in_tail),
        .out_ready   (out_ready),
        .gnt         (gnt),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [12:0] model_outputs();
        logic [4:0] g;
        logic       b;
        b = (m_owner >= 0);
        g = b ? 5'(1 << m_owner) : 5'b0;
        return {g, b, (b && out_ready) ? g : 5'b0, b ? in_valid[m_owner] : 1'b0, m_err};
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_wait  = 0;
        m_err   = 1'b0;
    endtask

    task automatic model_update();
        bit moved;
        m_err = 1'b0;
        if (m_owner < 0) begin
            for (int k = 0; k < 5; k++) begin
                int p;
                p = (m_ptr + k) % 5;
                if (req[p]) begin
                    m_owner = p;
                    m_wait  = 0;
                    break;
                end
            end
        end else begin
            moved = in_valid[m_owner] && out_ready;
            if (moved && in_tail[m_owner]) begin
                m_ptr   = (m_owner + 1) % 5;
                m_owner = -1;
            end else if (moved) begin
                m_wait = 0;
            end else begin
                m_wait++;
                if (m_wait == TIMEOUT) begin
                    m_ptr   = (m_owner + 1) % 5;
                    m_owner = -1;
                    m_err   = 1'b1;
                end
            end
        end
    endtask

    task automatic drive(input logic [4:0] r, input logic [4:0] v,
                         input logic [4:0] t, input logic o);
        req       = r;
        in_valid  = v;
        in_tail   = t;
        out_ready = o;
        #1;
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(5'b0, 5'b0, 5'b0, 1'b0);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({gnt, busy, err_timeout} !== 7'b0) $display("FAIL reset_hold: observed %b required %b", {gnt, busy, err_timeout}, 7'b0);
        else n_pass++;
        rst_n = 1'b1;
        drive(5'b0, 5'b11111, 5'b0, 1'b1);
        n_checks++;
        if ({gnt, busy, in_ready, out_valid, err_timeout} !== 13'b0) $display("FAIL reset_state: observed %b required %b", {gnt, busy, in_ready, out_valid, err_timeout}, 13'b0);
        else n_pass++;
        tick();
    endtask

    task automatic test_first_grant();
        do_reset();
        drive(5'b10110, 5'b0, 5'b0, 1'b1);
        tick();
        drive(5'b10110, 5'b00010, 5'b00010, 1'b1);
        n_checks++;
        if ({gnt, in_ready} !== {5'b00010, 5'b00010}) $display("FAIL first_grant: observed %b required %b", {gnt, in_ready}, {5'b00010, 5'b00010});
        else n_pass++;
        tick();
        drive(5'b10110, 5'b0, 5'b0, 1'b1);
        n_checks++;
        if ({gnt, busy} !== 6'b0) $display("FAIL tail_release: observed %b required %b", {gnt, busy}, 6'b0);
        else n_pass++;
        tick();
        drive(5'b10110, 5'b0, 5'b0, 1'b1);
        n_checks++;
        if (gnt !== 5'b00100) $display("FAIL next_after_ptr: observed %b required %b", gnt, 5'b00100);
        else n_pass++;
        n_checks++;
        if ({gnt, busy, in_ready, out_valid, err_timeout} !== model_outputs()) $display("FAIL first_grant_model: observed %b required %b", {gnt, busy, in_ready, out_valid, err_timeout}, model_outputs());
        else n_pass++;
        tick();
    endtask

    task automatic test_round_robin();
        int fcnt[5];
        logic [4:0] prev;
        int gap;
        bit started;
        do_reset();
        exp_q = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        foreach (fcnt[i]) fcnt[i] = 0;
        prev = 5'b0;
        gap = 0;
        started = 1'b0;
        for (int c = 0; c < 24; c++) begin
            logic [4:0] t;
            for (int i = 0; i < 5; i++) t[i] = (fcnt[i] == 2);
            drive(5'b11111, 5'b11111, t, 1'b1);
            n_checks++;
            if ({gnt, busy, in_ready, out_valid, err_timeout} !== model_outputs()) $display("FAIL rr_model c=%0d: observed %b required %b", c, {gnt, busy, in_ready, out_valid, err_timeout}, model_outputs());
            else n_pass++;
            if (gnt == 5'b0) begin
                gap++;
            end else if (prev == 5'b0) begin
                logic [2:0] idx;
                idx = 3'd0;
                for (int i = 0; i < 5; i++) if (gnt[i]) idx = 3'(i);
                n_checks++;
                if (exp_q.size() == 0 || idx !== exp_q[0]) $display("FAIL rr_order: observed %0d required %0d", idx, (exp_q.size() == 0) ? 7 : int'(exp_q[0]));
                else n_pass++;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                if (started) begin
                    n_checks++;
                    if (gap != 1) $display("FAIL rr_gap: observed %0d idle cycles required 1", gap);
                    else n_pass++;
                end
                started = 1'b1;
                gap = 0;
            end
            prev = gnt;
            if (m_owner >= 0) fcnt[m_owner] = (fcnt[m_owner] == 2) ? 0 : fcnt[m_owner] + 1;
            tick();
        end
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL rr_all_served: observed %0d grants outstanding required 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_stall();
        int moved;
        logic [4:0] ready_pat;
        logic [4:0] tail_pat;
        do_reset();
        drive(5'b01000, 5'b0, 5'b0, 1'b1);
        tick();
        moved = 0;
        // head, 4 stalled cycles, body, tail
        ready_pat = 5'b0;
        for (int c = 0; c < 7; c++) begin
            logic o;
            o = !(c >= 1 && c <= 4);
            tail_pat = (c == 6) ? 5'b01000 : 5'b0;
            drive(5'b0, 5'b01000, tail_pat, o);
            n_checks++;
            if ({gnt, busy, in_ready, out_valid, err_timeout} !== model_outputs()) $display("FAIL stall_model c=%0d: observed %b required %b", c, {gnt, busy, in_ready, out_valid, err_timeout}, model_outputs());
            else n_pass++;
            if (!o) begin
                n_checks++;
                if ({gnt, in_ready} !== {5'b01000, ready_pat}) $display("FAIL stall_hold c=%0d: observed %b required %b", c, {gnt, in_ready}, {5'b01000, ready_pat});
                else n_pass++;
            end
            if (in_ready[3] && out_valid) moved++;
            tick();
        end
        n_checks++;
        if (moved != 3) $display("FAIL stall_flits: observed %0d transfers required 3", moved);
        else n_pass++;
        drive(5'b0, 5'b0, 5'b0, 1'b1);
        n_checks++;
        if (gnt !== 5'b0) $display("FAIL stall_release: observed %b required %b", gnt, 5'b0);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int release_at;
        int err_cnt;
        int err_at;
        do_reset();
        drive(5'b00001, 5'b0, 5'b0, 1'b1);
        tick();
        release_at = -1;
        err_cnt = 0;
        err_at = -1;
        for (int c = 0; c < TIMEOUT + 2; c++) begin
            drive(5'b0, 5'b0, 5'b0, 1'b1);
            n_checks++;
            if ({gnt, busy, in_ready, out_valid, err_timeout} !== model_outputs()) $display("FAIL timeout_model c=%0d: observed %b required %b", c, {gnt, busy, in_ready, out_valid, err_timeout}, model_outputs());
            else n_pass++;
            if (gnt == 5'b0 && release_at < 0) release_at = c;
            if (err_timeout) begin
                err_cnt++;
                err_at = c;
            end
            tick();
        end
        n_checks++;
        if (release_at != TIMEOUT) $display("FAIL timeout_release: observed cycle %0d required %0d", release_at, TIMEOUT);
        else n_pass++;
        n_checks++;
        if (err_cnt != 1 || err_at != TIMEOUT) $display("FAIL timeout_pulse: observed %0d pulses at %0d required 1 at %0d", err_cnt, err_at, TIMEOUT);
        else n_pass++;
        drive(5'b00011, 5'b0, 5'b0, 1'b1);
        tick();
        drive(5'b0, 5'b0, 5'b0, 1'b1);
        n_checks++;
        if (gnt !== 5'b00010) $display("FAIL timeout_ptr: observed %b required %b", gnt, 5'b00010);
        else n_pass++;
    endtask

    task automatic test_tail_at_timeout();
        do_reset();
        drive(5'b00001, 5'b0, 5'b0, 1'b1);
        tick();
        for (int c = 0; c < TIMEOUT - 1; c++) begin
            drive(5'b0, 5'b0, 5'b0, (c % 2) == 0);
            n_checks++;
            if ({gnt, busy, in_ready, out_valid, err_timeout} !== model_outputs()) $display("FAIL tail_to_model c=%0d: observed %b required %b", c, {gnt, busy, in_ready, out_valid, err_timeout}, model_outputs());
            else n_pass++;
            tick();
        end
        drive(5'b0, 5'b00001, 5'b00001, 1'b1);
        n_checks++;
        if ({gnt, out_valid, err_timeout} !== {5'b00001, 1'b1, 1'b0}) $display("FAIL tail_to_last: observed %b required %b", {gnt, out_valid, err_timeout}, {5'b00001, 1'b1, 1'b0});
        else n_pass++;
        tick();
        drive(5'b0, 5'b0, 5'b0, 1'b1);
        n_checks++;
        if ({gnt, busy, err_timeout} !== 7'b0) $display("FAIL tail_to_release: observed %b required %b", {gnt, busy, err_timeout}, 7'b0);
        else n_pass++;
        tick();
        drive(5'b0, 5'b0, 5'b0, 1'b1);
        n_checks++;
        if (err_timeout !== 1'b0) $display("FAIL tail_to_noerr: observed %b required %b", err_timeout, 1'b0);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(5'b00100, 5'b0, 5'b0, 1'b1);
        tick();
        drive(5'b0, 5'b00100, 5'b0, 1'b1);
        n_checks++;
        if (gnt !== 5'b00100) $display("FAIL areset_pre: observed %b required %b", gnt, 5'b00100);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({gnt, busy, in_ready, out_valid} !== 12'b0) $display("FAIL areset_now: observed %b required %b", {gnt, busy, in_ready, out_valid}, 12'b0);
        else n_pass++;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(5'b00001, 5'b0, 5'b0, 1'b1);
        tick();
        drive(5'b0, 5'b0, 5'b0, 1'b1);
        n_checks++;
        if (gnt !== 5'b00001) $display("FAIL areset_regrant: observed %b required %b", gnt, 5'b00001);
        else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            logic [4:0] t;
            for (int i = 0; i < 5; i++) t[i] = ($urandom_range(0, 2) == 0);
            drive(5'($urandom), 5'($urandom), t, $urandom_range(0, 3) != 0);
            n_checks++;
            if ({gnt, busy, in_ready, out_valid, err_timeout} !== model_outputs()) $display("FAIL random c=%0d: observed %b required %b", c, {gnt, busy, in_ready, out_valid, err_timeout}, model_outputs());
            else n_pass++;
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        model_reset();
        test_reset();
        test_first_grant();
        test_round_robin();
        test_stall();
        test_timeout();
        test_tail_at_timeout();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
